code_loader: RTL and testbench



---
 rtl/code_loader_if.sv | 24 ++
 rtl/code_loader.sv | 169 ++++++++++++++++
 tb/tb_code_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_loader_if.sv
// Byte-stream, control and code-memory bus bundle for code_loader.
// The loader uses the slave modport; the surrounding system uses master.
interface code_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_start;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        boot_done;
  logic        load_error;

  modport master (
    output rx_data, rx_valid, load_start, fetch_addr,
    input  rx_ready, mem_addr, mem_we, mem_wdata, boot_done, load_error
  );

  modport slave (
    input  rx_data, rx_valid, load_start, fetch_addr,
    output rx_ready, mem_addr, mem_we, mem_wdata, boot_done, load_error
  );
endinterface

// File: rtl/code_loader.sv
// Boot loader: packs a big-endian length-prefixed byte stream into code memory,
// then hands the memory port to instruction fetch. Optional: CODE_LOADER_CHECKSUM_EN.
module code_loader #(
  parameter int unsigned CODE_SIZE = 32767
) (
  input logic          clk,
  input logic          rst,
  code_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef CODE_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [32:0] MAX_LEN = 33'(CODE_SIZE) + 33'd1;

  state_e      state_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] len_q;
  logic [23:0] word_q;
  logic [31:0] index_q;
  logic        rx_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_wdata_q;
  logic        boot_done_q;
  logic        load_error_q;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        xfer;
  logic [31:0] len_d;
  logic [31:0] word_d;
  logic [31:0] index_d;

  assign xfer    = bus.rx_valid && rx_ready_q;
  assign len_d   = {len_q[23:0], bus.rx_data};
  assign word_d  = {word_q, bus.rx_data};
  assign index_d = index_q + 32'd1;

  // NOTE: clocked state uses non-blocking assignments only, so every branch
  // below reads the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LEN;
      byte_cnt_q   <= 2'd0;
      len_q        <= 32'd0;
      word_q       <= 24'd0;
      index_q      <= 32'd0;
      rx_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
      boot_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_q       <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_LEN: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            len_q      <= len_d;
            if (byte_cnt_q == 2'd3) begin
              if (len_d == 32'd0) begin
                state_q     <= S_DONE;
                rx_ready_q  <= 1'b0;
                boot_done_q <= 1'b1;
              end else if ({1'b0, len_d} > MAX_LEN) begin
                state_q      <= S_ERROR;
                rx_ready_q   <= 1'b0;
                load_error_q <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= word_d[23:0];
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ bus.rx_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              state_q     <= S_WRITE;
              rx_ready_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d;
            end
          end
        end

        S_WRITE: begin
          mem_we_q <= 1'b0;
          index_q  <= index_d;
          if (index_d == len_q) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state_q    <= S_CHECK;
            rx_ready_q <= 1'b1;
`else
            state_q     <= S_DONE;
            boot_done_q <= 1'b1;
`endif
          end else begin
            state_q    <= S_DATA;
            rx_ready_q <= 1'b1;
          end
        end

`ifdef CODE_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q     <= S_DONE;
              boot_done_q <= 1'b1;
            end else begin
              state_q      <= S_ERROR;
              load_error_q <= 1'b1;
            end
          end
        end
`endif

        S_DONE, S_ERROR: begin
          if (bus.load_start) begin
            state_q      <= S_LEN;
            byte_cnt_q   <= 2'd0;
            len_q        <= 32'd0;
            word_q       <= 24'd0;
            index_q      <= 32'd0;
            rx_ready_q   <= 1'b1;
            boot_done_q  <= 1'b0;
            load_error_q <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
          end
        end

        default: begin
          state_q    <= S_LEN;
          rx_ready_q <= 1'b1;
          mem_we_q   <= 1'b0;
        end
      endcase
    end
  end

  // Fetch address bypasses all registers so read latency is the bare memory's.
  assign bus.mem_addr   = (state_q == S_DONE)  ? bus.fetch_addr :
                          (state_q == S_ERROR) ? 32'd0 : index_q;
  assign bus.rx_ready   = rx_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.boot_done  = boot_done_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: stream-level model predicts writes and
// final outcome; a negedge monitor checks every write and the DONE/ERROR outputs.
module tb_code_loader;

  localparam int unsigned CODE_SIZE = 32767;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  code_loader_if bus ();

  code_loader #(.CODE_SIZE(CODE_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cnt  = 0;
  wr_t  exp_wr[$];
  wr_t  wr_log[$];
  logic prev_we   = 1'b0;
  logic prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: length prefix, big-endian words, optional XOR trailer.
  function automatic void model(input logic [7:0] s[$], output logic exp_err);
    logic [31:0] n;
    logic [7:0]  x;
    wr_t         w;
    n       = {s[0], s[1], s[2], s[3]};
    exp_err = 1'b0;
    x       = 8'h00;
    if (longint'(n) > longint'(CODE_SIZE) + 1) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w.addr = 32'(i);
      w.data = {s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]};
      exp_wr.push_back(w);
      x = x ^ s[4+4*i] ^ s[5+4*i] ^ s[6+4*i] ^ s[7+4*i];
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    if (n != 0 && s[4+4*int'(n)] != x) exp_err = 1'b1;
`endif
  endfunction

  // Appends the correct trailer byte when the checksum build is selected.
  function automatic void add_csum(inout logic [7:0] s[$]);
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 4; i < s.size(); i++) x = x ^ s[i];
    s.push_back(x);
`endif
  endfunction

  task automatic send_bytes(input logic [7:0] s[$]);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    while (i < s.size()) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
      @(negedge clk);
      rdy = bus.rx_ready;
      @(posedge clk);
      #1;
      if (rdy) i++;
      guard++;
      if (guard > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: sent %0d of %0d bytes", i, s.size());
        break;
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic run_stream(input string name, input logic [7:0] s[$]);
    logic exp_err;
    model(s, exp_err);
    send_bytes(s);
    for (int k = 0; k < 10 && !(bus.boot_done || bus.load_error); k++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_load_error"}, 32'(bus.load_error), 32'(exp_err));
    check({name, "_boot_done"}, 32'(bus.boot_done), 32'(!exp_err));
    check({name, "_writes_left"}, exp_wr.size(), 0);
  endtask

  task automatic pulse_load_start();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
  endtask

  task automatic clear_logs();
    we_cnt = 0;
    wr_log.delete();
  endtask

  always @(negedge clk) begin
    wr_t e;
    wr_t o;
    if (rst) begin
      prev_we   = 1'b0;
      prev_last = 1'b0;
      if (bus.mem_we) check("we_during_reset", 32'(bus.mem_we), 0);
    end else begin
      if (prev_we) begin
        if (prev_last) begin
`ifdef CODE_LOADER_CHECKSUM_EN
          check("after_last_write_check", {30'd0, bus.rx_ready, bus.boot_done}, 32'b10);
`else
          check("after_last_write_done", 32'(bus.boot_done), 1);
`endif
        end else begin
          check("after_write_resume", {30'd0, bus.rx_ready, bus.mem_we}, 32'b10);
        end
      end
      prev_we   = bus.mem_we;
      prev_last = 1'b0;
      if (bus.mem_we) begin
        we_cnt++;
        o.addr = bus.mem_addr;
        o.data = bus.mem_wdata;
        wr_log.push_back(o);
        check("write_rx_ready_low", 32'(bus.rx_ready), 0);
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", bus.mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          check("write_addr", bus.mem_addr, e.addr);
          check("write_data", bus.mem_wdata, e.data);
          prev_last = (exp_wr.size() == 0);
        end
      end
      if (bus.boot_done) begin
        check("done_fetch_passthrough", bus.mem_addr, bus.fetch_addr);
        check("done_outputs", {29'd0, bus.rx_ready, bus.mem_we, bus.load_error}, 0);
      end
      if (bus.load_error) begin
        check("error_outputs", {bus.mem_addr[28:0], bus.rx_ready, bus.mem_we, bus.boot_done}, 0);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic       e;

    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.load_start = 1'b0;
    bus.fetch_addr = 32'd0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready",   32'(bus.rx_ready), 1);
    check("rst_mem_we",     32'(bus.mem_we), 0);
    check("rst_mem_addr",   bus.mem_addr, 0);
    check("rst_mem_wdata",  bus.mem_wdata, 0);
    check("rst_boot_done",  32'(bus.boot_done), 0);
    check("rst_load_error", 32'(bus.load_error), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-word image, rx_valid held high throughout.
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    add_csum(s);
    run_stream("n2", s);
    check("n2_we_count", we_cnt, 2);
    if (wr_log.size() >= 2) begin
      check("n2_w0_addr", wr_log[0].addr, 32'd0);
      check("n2_w0_data", wr_log[0].data, 32'hDEADBEEF);
      check("n2_w1_addr", wr_log[1].addr, 32'd1);
      check("n2_w1_data", wr_log[1].data, 32'h01234567);
    end
    bus.fetch_addr = 32'd1;
    #1;
    check("n2_fetch_addr_1", bus.mem_addr, 32'd1);
    @(posedge clk);
    #1;
    bus.fetch_addr = 32'h0000_7FFF;
    #1;
    check("n2_fetch_addr_7fff", bus.mem_addr, 32'h0000_7FFF);

    // Back to LEN; boot_done drops the cycle after load_start.
    pulse_load_start();
    check("restart_boot_done", 32'(bus.boot_done), 0);
    check("restart_rx_ready", 32'(bus.rx_ready), 1);
    check("restart_mem_addr", bus.mem_addr, 0);

    // Empty image: DONE immediately after the 4th length byte.
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h00};
    model(s, e);
    send_bytes(s);
    check("n0_done_next_cycle", 32'(bus.boot_done), 1);
    check("n0_rx_ready", 32'(bus.rx_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    check("n0_we_count", we_cnt, 0);

    // Oversized image: N = CODE_SIZE+2.
    pulse_load_start();
    clear_logs();
    s = '{8'h00, 8'h00, 8'h80, 8'h01};
    model(s, e);
    send_bytes(s);
    check("big_load_error", 32'(bus.load_error), 1);
    check("big_rx_ready", 32'(bus.rx_ready), 0);
    check("big_boot_done", 32'(bus.boot_done), 0);
    repeat (2) @(posedge clk);
    #1;
    check("big_we_count", we_cnt, 0);
    pulse_load_start();
    check("big_restart_error", 32'(bus.load_error), 0);
    check("big_restart_ready", 32'(bus.rx_ready), 1);

    // Largest legal length prefix is accepted as data, then abandoned by rst.
    s = '{8'h00, 8'h00, 8'h80, 8'h00};
    send_bytes(s);
    check("max_len_not_error", 32'(bus.load_error), 0);
    check("max_len_rx_ready", 32'(bus.rx_ready), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-pressure across WRITE: bytes held during WRITE must appear once.
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum(s);
    run_stream("bp", s);
    check("bp_we_count", we_cnt, 2);
    pulse_load_start();
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    add_csum(s);
    run_stream("n1", s);
    check("n1_we_count", we_cnt, 1);

    // Reset after two data bytes: no write, counters cleared, clean reload.
    pulse_load_start();
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'hBB};
    send_bytes(s);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_rx_ready", 32'(bus.rx_ready), 1);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_boot_done", 32'(bus.boot_done), 0);
    check("mid_rst_we_count", we_cnt, 0);
    s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78};
    add_csum(s);
    run_stream("reload", s);
    if (wr_log.size() >= 1) begin
      check("reload_w0_addr", wr_log[0].addr, 32'd0);
      check("reload_w0_data", wr_log[0].data, 32'hCAFEF00D);
    end else begin
      check("reload_write_seen", wr_log.size(), 2);
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    pulse_load_start();
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_stream("csum_ok", s);
    check("csum_ok_done", 32'(bus.boot_done), 1);
    pulse_load_start();
    clear_logs();
    s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_stream("csum_bad", s);
    check("csum_bad_error", 32'(bus.load_error), 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
